// File: rtl/store_buffer.sv
// store_buffer: small in-order store queue between the execute-stage store
// path and the data/instruction memory write ports.
//
// Each accepted store is turned into byte enables plus lane-aligned data.
// It is then split into a dmem mask and an imem mask by address region and
// queued. Entries drain from the head one per cycle under mem_valid/mem_ready.
// ld_hazard flags a load whose word address matches any queued entry.
//
// Handshakes:
//   st_valid/st_ready   : a store transfers on a cycle where both are high.
//                         st_ready never depends on st_valid.
//   mem_valid/mem_ready : the head entry transfers on a cycle where both are
//                         high. mem_ready is ignored while mem_valid is low.
//
// Optional feature: define STORE_BUF_COALESCE_EN to merge a store into the
// most recently enqueued entry when both have the same word address.
//
// There is no FSM in this block. The queue state is head_q, tail_q, count_q
// and vld_q, and count and empty expose it.

module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int AWIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               st_funct3,
  input  logic                     st_pc30,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [31:0]              mem_din,
  output logic [3:0]               dmem_wea,
  output logic [3:0]               imem_wea,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue control state
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] vld_q, vld_d;

  // Entry payload (not reset; only read through vld_q / count_q)
  logic [AWIDTH-1:0] addr_q  [DEPTH];
  logic [31:0]       data_q  [DEPTH];
  logic [3:0]        dmask_q [DEPTH];
  logic [3:0]        imask_q [DEPTH];

  // Decoded incoming store
  logic [3:0]        st_mask;
  logic [31:0]       st_wdata;
  logic              st_f3_ok;
  logic [3:0]        st_dmask;
  logic [3:0]        st_imask;
  logic [AWIDTH-1:0] st_waddr;
  logic              st_enq_cand;

  // Handshake and pointer helpers
  logic              pop;
  logic              accept;
  logic              do_push;
  logic              do_merge;
  logic [PW-1:0]     last_ptr;
  logic [AWIDTH-1:0] ld_waddr;

  // Merge datapath
  logic [31:0]       merge_data;
  logic [3:0]        merge_lanes;

  // Upper address bits and unused data bits are decoded only partially
  logic unused_ok;
  assign unused_ok = ^{st_addr, ld_addr, st_data};

  assign st_waddr = st_addr[AWIDTH+1:2];
  assign ld_waddr = ld_addr[AWIDTH+1:2];
  assign last_ptr = tail_q - PW'(1);

  // Byte-enable mask and lane alignment from funct3 and the low address bits
  always_comb begin
    st_mask  = 4'b0000;
    st_wdata = 32'h0;
    st_f3_ok = 1'b1;
    unique case (st_funct3)
      3'b000: begin
        st_mask  = 4'b0001 << st_addr[1:0];
        st_wdata = {24'h0, st_data[7:0]} << {st_addr[1:0], 3'b000};
      end
      3'b001: begin
        if (st_addr[1]) begin
          st_mask  = 4'b1100;
          st_wdata = {st_data[15:0], 16'h0};
        end else begin
          st_mask  = 4'b0011;
          st_wdata = {16'h0, st_data[15:0]};
        end
      end
      3'b010: begin
        st_mask  = 4'b1111;
        st_wdata = st_data;
      end
      default: begin
        st_mask  = 4'b0000;
        st_wdata = 32'h0;
        st_f3_ok = 1'b0;
      end
    endcase
  end

  // Region decode: bit 28 selects dmem, bit 29 plus PC bit 30 selects imem
  always_comb begin
    st_dmask    = st_addr[28] ? st_mask : 4'b0000;
    st_imask    = (st_addr[29] && st_pc30) ? st_mask : 4'b0000;
    st_enq_cand = st_f3_ok && ((st_dmask | st_imask) != 4'b0000);
  end

  assign pop = mem_valid && mem_ready;

`ifdef STORE_BUF_COALESCE_EN
  logic merge_hit;

  // A store may fold into the youngest entry unless that entry leaves this cycle
  always_comb begin
    merge_hit = st_enq_cand && (count_q != '0) && vld_q[last_ptr] &&
                (addr_q[last_ptr] == st_waddr) &&
                !(pop && (last_ptr == head_q));
    st_ready  = (count_q < DEPTH_C) || merge_hit;
  end

  assign do_merge = accept && merge_hit;
`else
  assign st_ready = (count_q < DEPTH_C);
  assign do_merge = 1'b0;
`endif

  assign accept  = st_valid && st_ready;
  assign do_push = accept && st_enq_cand && !do_merge;

  // Merged lanes take the new bytes, the other lanes keep the queued bytes
  always_comb begin
    merge_lanes = st_dmask | st_imask;
    merge_data  = data_q[last_ptr];
    for (int b = 0; b < 4; b++) begin
      if (merge_lanes[b]) merge_data[8*b +: 8] = st_wdata[8*b +: 8];
    end
  end

  // Next-state for pointers, occupancy and valid bits
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    vld_d   = vld_q;
    if (pop) begin
      head_d        = head_q + PW'(1);
      vld_d[head_q] = 1'b0;
    end
    if (do_push) begin
      tail_d        = tail_q + PW'(1);
      vld_d[tail_q] = 1'b1;
    end
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      vld_q   <= vld_d;
    end
  end

  // Payload write: new entry at tail, or merge into the youngest entry
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      addr_q[tail_q]  <= st_waddr;
      data_q[tail_q]  <= st_wdata;
      dmask_q[tail_q] <= st_dmask;
      imask_q[tail_q] <= st_imask;
    end else if (!rst && do_merge) begin
      data_q[last_ptr]  <= merge_data;
      dmask_q[last_ptr] <= dmask_q[last_ptr] | st_dmask;
      imask_q[last_ptr] <= imask_q[last_ptr] | st_imask;
    end
  end

  // Load alias check against every valid queued entry, including one popping now
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == ld_waddr)) ld_hazard = ld_valid;
    end
  end

  // Head entry outputs, forced to zero while the queue is empty
  always_comb begin
    mem_valid = (count_q != '0);
    empty     = (count_q == '0);
    count     = count_q;
    mem_addr  = mem_valid ? addr_q[head_q]  : '0;
    mem_din   = mem_valid ? data_q[head_q]  : 32'h0;
    dmem_wea  = mem_valid ? dmask_q[head_q] : 4'b0000;
    imem_wea  = mem_valid ? imask_q[head_q] : 4'b0000;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: self-checking bench for store_buffer (DEPTH=4, AWIDTH=14).
// Expected entries {word addr[13:0], data[31:0], dmem mask, imem mask} are
// pushed to exp_q when a store is accepted and compared at the head each cycle.
// Define STORE_BUF_COALESCE_EN here too when the DUT is built with merging.

module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int W     = 54;

  // Clock / reset
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_funct3;
  logic        st_pc30;
  logic        ld_valid, ld_hazard;
  logic [31:0] ld_addr;
  logic        mem_valid, mem_ready;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  dmem_wea, imem_wea;
  logic [2:0]  count;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH), .AWIDTH(14)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3), .st_pc30(st_pc30),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .dmem_wea(dmem_wea), .imem_wea(imem_wea),
    .count(count), .empty(empty)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit last_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference entry built lane by lane
  function automatic logic [W-1:0] build_entry(input logic [31:0] a, input logic [31:0] d,
                                               input logic [2:0] f, input logic pc, output bit ok);
    logic [3:0]  m;
    logic [31:0] w;
    logic [3:0]  dm, im;
    bit sel;
    m = 4'b0; w = 32'h0;
    for (int b = 0; b < 4; b++) begin
      sel = (f == 3'd0 && int'(a[1:0]) == b) || (f == 3'd1 && int'(a[1]) == b / 2) || (f == 3'd2);
      if (sel) begin
        m[b] = 1'b1;
        if (f == 3'd0)      w[8*b +: 8] = d[7:0];
        else if (f == 3'd1) w[8*b +: 8] = (b % 2 == 1) ? d[15:8] : d[7:0];
        else                w[8*b +: 8] = d[8*b +: 8];
      end
    end
    dm = a[28] ? m : 4'b0;
    im = (a[29] && pc) ? m : 4'b0;
    ok = (f <= 3'd2) && ((dm | im) != 4'b0);
    return {a[15:2], w, dm, im};
  endfunction

  // One clock: compare at the falling edge, update the model, return after the rising edge
  task automatic step();
    logic [W-1:0] e, old;
    logic [3:0] nm;
    bit ok, pop, merge, ready_m, haz;
    int sz;
    @(negedge clk);
    sz = exp_q.size();
    check("mem_valid", 64'(mem_valid), 64'(sz != 0));
    check("count", 64'(count), 64'(sz));
    check("empty", 64'(empty), 64'(sz == 0));
    if (sz != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(exp_q[0][53:40]));
      check("mem_din", 64'(mem_din), 64'(exp_q[0][39:8]));
      check("dmem_wea", 64'(dmem_wea), 64'(exp_q[0][7:4]));
      check("imem_wea", 64'(imem_wea), 64'(exp_q[0][3:0]));
    end else begin
      check("idle_outs", {mem_addr, mem_din, dmem_wea, imem_wea}, 64'h0);
    end
    haz = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][53:40] == ld_addr[15:2]) haz = ld_valid;
    check("ld_hazard", 64'(ld_hazard), 64'(haz));
    pop = (sz != 0) && mem_ready;
    e = build_entry(st_addr, st_data, st_funct3, st_pc30, ok);
    merge = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
    merge = ok && (sz != 0) && (exp_q[sz-1][53:40] == e[53:40]) && !(pop && sz == 1);
`endif
    ready_m = (sz < DEPTH) || merge;
    check("st_ready", 64'(st_ready), 64'(ready_m));
    last_acc = st_valid && ready_m && !rst;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (last_acc && ok && merge) begin
        old = exp_q[sz-1];
        nm = e[7:4] | e[3:0];
        for (int b = 0; b < 4; b++) if (nm[b]) old[8 + 8*b +: 8] = e[8 + 8*b +: 8];
        old[7:4] = old[7:4] | e[7:4];
        old[3:0] = old[3:0] | e[3:0];
        exp_q[sz-1] = old;
      end
      if (pop) void'(exp_q.pop_front());
      if (last_acc && ok && !merge) exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Driver: present a store and hold it until accepted (bounded)
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f, input logic pc);
    bit done;
    done = 1'b0;
    st_addr = a; st_data = d; st_funct3 = f; st_pc30 = pc; st_valid = 1'b1;
    for (int k = 0; k < 16 && !done; k++) begin
      step();
      done = last_acc;
    end
    if (!done) check("accept_timeout", 64'(0), 64'(1));
    st_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rd;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
    st_pc30 = 1'b0; ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_st_ready", 64'(st_ready), 64'(1));
    check("rst_mem_valid", 64'(mem_valid), 64'(0));
    check("rst_outs", {mem_addr, mem_din, dmem_wea, imem_wea}, 64'h0);
    check("rst_count", 64'(count), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_ld_hazard", 64'(ld_hazard), 64'(0));

    // SB into empty queue appears next cycle, then drains
    mem_ready = 1'b1;
    send(32'h1000_0003, 32'h0000_00AB, 3'b000, 1'b0);
    check("sb_valid", 64'(mem_valid), 64'(1));
    check("sb_din", 64'(mem_din), 64'hAB00_0000);
    check("sb_dwea", 64'(dmem_wea), 64'b1000);
    check("sb_iwea", 64'(imem_wea), 64'b0000);
    step();
    check("sb_drained", 64'(empty), 64'(1));

    // SH to both regions, with and without PC bit 30
    mem_ready = 1'b0;
    send(32'h3000_0002, 32'h0000_1234, 3'b001, 1'b1);
    check("sh_dwea", 64'(dmem_wea), 64'b1100);
    check("sh_iwea", 64'(imem_wea), 64'b1100);
    check("sh_din", 64'(mem_din), 64'h1234_0000);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    send(32'h3000_0002, 32'h0000_1234, 3'b001, 1'b0);
    check("sh_nopc_iwea", 64'(imem_wea), 64'b0000);
    check("sh_nopc_dwea", 64'(dmem_wea), 64'b1100);
    mem_ready = 1'b1;
    step();

    // Dropped stores: no region, bad funct3
    send(32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 1'b1);
    check("drop_region_count", 64'(count), 64'(0));
    send(32'h1000_0000, 32'hDEAD_BEEF, 3'b011, 1'b1);
    check("drop_f3_count", 64'(count), 64'(0));
    check("drop_valid", 64'(mem_valid), 64'(0));

    // Fill, block, then drain in order with a concurrent push
    mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(32'h1000_0100 + 32'(4*i), $urandom, 3'b010, 1'b0);
    check("full_ready", 64'(st_ready), 64'(0));
    check("full_count", 64'(count), 64'(4));
    st_addr = 32'h1000_0200; st_data = 32'h5555_AAAA; st_funct3 = 3'b010; st_valid = 1'b1;
    step();
    check("full_blocked", 64'(last_acc), 64'(0));
    mem_ready = 1'b1;
    step();
    check("pop_count", 64'(count), 64'(3));
    step();
    check("pushpop_acc", 64'(last_acc), 64'(1));
    check("pushpop_count", 64'(count), 64'(3));
    st_valid = 1'b0;
    repeat (4) step();
    check("drain_empty", 64'(empty), 64'(1));

    // Load hazard
    mem_ready = 1'b0;
    send(32'h1000_0040, 32'h0102_0304, 3'b010, 1'b0);
    ld_valid = 1'b1; ld_addr = 32'h1000_0042; #1;
    check("haz_hit", 64'(ld_hazard), 64'(1));
    ld_addr = 32'h1000_0044; #1;
    check("haz_miss", 64'(ld_hazard), 64'(0));
    ld_addr = 32'h1000_0042; mem_ready = 1'b1; #1;
    check("haz_popping", 64'(ld_hazard), 64'(1));
    step();
    check("haz_cleared", 64'(ld_hazard), 64'(0));
    ld_valid = 1'b0;

    // Reset with three queued entries
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h1000_0300 + 32'(4*i), $urandom, 3'b010, 1'b0);
    check("pre_rst_count", 64'(count), 64'(3));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_count", 64'(count), 64'(0));
    check("post_rst_valid", 64'(mem_valid), 64'(0));
    check("post_rst_dwea", 64'(dmem_wea), 64'(0));

`ifdef STORE_BUF_COALESCE_EN
    send(32'h1000_0000, 32'h0000_0011, 3'b000, 1'b0);
    send(32'h1000_0001, 32'h0000_0022, 3'b000, 1'b0);
    check("coal_count", 64'(count), 64'(1));
    check("coal_dwea", 64'(dmem_wea), 64'b0011);
    check("coal_din", 64'(mem_din), 64'h0000_2211);
    mem_ready = 1'b1;
    repeat (2) step();
`endif

    // Random traffic over a few words and regions
    for (int i = 0; i < 120; i++) begin
      ra = (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      rd = $urandom;
      st_addr = ra; st_data = rd;
      st_funct3 = 3'($urandom_range(0, 3));
      st_pc30 = 1'($urandom_range(0, 1));
      st_valid = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr = 32'h1000_0000 | (32'($urandom_range(0, 3)) << 2);
      step();
    end
    st_valid = 1'b0; ld_valid = 1'b0; mem_ready = 1'b1;
    repeat (6) step();
    check("final_empty", 64'(empty), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
